// File: rtl/chesssoc_mailbox_master.sv
// chesssoc_mailbox_master: Avalon-MM master that posts a move command plus a sequence
// number into the 4-word mailbox, polls the ack word until software echoes the sequence
// number, fetches the response word and hands it out over a valid/ready handshake.
// Optional build macro MAILBOX_TIMEOUT_EN adds a response timeout (rsp_timeout).
module chesssoc_mailbox_master #(
    parameter int unsigned POLL_GAP       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [1:0]  avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [3:0] {
        StIdle, StWrCmd, StWrSeq, StGap, StPollRd,
        StPollChk, StRspRd, StRspCap, StClrAck, StOut
    } state_e;

    localparam logic [7:0] GapLoad = 8'(POLL_GAP);

    state_e      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] cmd_q, cmd_d;
    logic [7:0]  gap_q, gap_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        ack_match;

`ifdef MAILBOX_TIMEOUT_EN
    localparam logic [15:0] ToLoad = 16'(TIMEOUT_CYCLES);
    logic [15:0] to_q, to_d;
    logic        rsp_to_q, rsp_to_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
`endif

    // Ack counts only when the done flag is set and the echoed seq is ours.
    assign ack_match = avm_readdata[31] && (avm_readdata[7:0] == seq_q);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            seq_q      <= 8'd0;
            cmd_q      <= 16'd0;
            gap_q      <= 8'd0;
            rsp_data_q <= 32'd0;
`ifdef MAILBOX_TIMEOUT_EN
            to_q       <= 16'd0;
            rsp_to_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            cmd_q      <= cmd_d;
            gap_q      <= gap_d;
            rsp_data_q <= rsp_data_d;
`ifdef MAILBOX_TIMEOUT_EN
            to_q       <= to_d;
            rsp_to_q   <= rsp_to_d;
`endif
        end
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        cmd_d      = cmd_q;
        gap_d      = gap_q;
        rsp_data_d = rsp_data_q;
`ifdef MAILBOX_TIMEOUT_EN
        to_d       = to_q;
        rsp_to_d   = rsp_to_q;
`endif
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cmd_d   = cmd_data;
                    seq_d   = seq_q + 8'd1;
                    state_d = StWrCmd;
                end
            end
            StWrCmd: state_d = StWrSeq;
            StWrSeq: begin
                gap_d   = GapLoad;
`ifdef MAILBOX_TIMEOUT_EN
                to_d    = ToLoad;
`endif
                state_d = StGap;
            end
            StGap: begin
                // A zero gap still spends one cycle here.
                if (gap_q <= 8'd1) begin
                    state_d = StPollRd;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            StPollRd: state_d = StPollChk;
            StPollChk: begin
                if (ack_match) begin
                    state_d = StRspRd;
                end else begin
                    gap_d   = GapLoad;
                    state_d = StGap;
                end
            end
            StRspRd: state_d = StRspCap;
            StRspCap: begin
                rsp_data_d = avm_readdata;
`ifdef MAILBOX_TIMEOUT_EN
                rsp_to_d   = 1'b0;
`endif
                state_d    = StClrAck;
            end
            StClrAck: state_d = StOut;
            StOut: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef MAILBOX_TIMEOUT_EN
        // Expiry overrides polling, except that a same-cycle ack match wins.
        if (state_q == StGap || state_q == StPollRd || state_q == StPollChk) begin
            if (to_q == 16'd0) begin
                if (!(state_q == StPollChk && ack_match)) begin
                    state_d    = StClrAck;
                    rsp_data_d = 32'd0;
                    rsp_to_d   = 1'b1;
                end
            end else begin
                to_d = to_q - 16'd1;
            end
        end
`endif
    end

    // Avalon strobes, address and write data decoded from the current state.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_address    = 2'd0;
        avm_writedata  = 32'd0;
        case (state_q)
            StWrCmd: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_address    = 2'd0;
                avm_writedata  = {16'h0, cmd_q};
            end
            StWrSeq: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_address    = 2'd1;
                avm_writedata  = {24'h0, seq_q};
            end
            StPollRd: begin
                avm_chipselect = 1'b1;
                avm_read       = 1'b1;
                avm_address    = 2'd3;
            end
            StRspRd: begin
                avm_chipselect = 1'b1;
                avm_read       = 1'b1;
                avm_address    = 2'd2;
            end
            StClrAck: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_address    = 2'd3;
                avm_writedata  = 32'd0;
            end
            default: ;
        endcase
    end

    assign avm_byteenable = 4'b1111;
    assign cmd_ready      = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign rsp_valid      = (state_q == StOut);
    assign rsp_data       = rsp_data_q;
`ifdef MAILBOX_TIMEOUT_EN
    assign rsp_timeout    = rsp_to_q;
`else
    assign rsp_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_chesssoc_mailbox_master.sv
// Directed bench for chesssoc_mailbox_master with a behavioural mailbox slave model.
module tb_chesssoc_mailbox_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic [1:0]  avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'd0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chesssoc_mailbox_master #(.POLL_GAP(8), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    // Slave model configuration (driven by the test tasks only).
    logic        echo = 1'b0;
    int          ack_on_read = 1;
    logic [31:0] ack_value = 32'd0;
    logic [31:0] pre_ack_value = 32'd0;
    logic [31:0] rsp_value = 32'd0;

    // Slave model state and logs (driven by the model process only).
    int          cyc = 0;
    int          poll_cnt = 0;
    int          wr_cnt = 0;
    int          poll_total = 0;
    int          rsp_rd_total = 0;
    logic [7:0]  last_seq = 8'd0;
    logic [1:0]  wr_addr_log [0:2047];
    logic [31:0] wr_data_log [0:2047];
    int          poll_cyc_log [0:2047];

    // Mailbox slave: logs writes, returns ack/response with one cycle of read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_chipselect && avm_write) begin
            wr_addr_log[wr_cnt] <= avm_address;
            wr_data_log[wr_cnt] <= avm_writedata;
            wr_cnt <= wr_cnt + 1;
            if (avm_address == 2'd1) begin
                poll_cnt <= 0;
                last_seq <= avm_writedata[7:0];
            end
        end
        if (avm_chipselect && avm_read) begin
            if (avm_address == 2'd3) begin
                poll_cyc_log[poll_total] <= cyc;
                poll_total <= poll_total + 1;
                poll_cnt <= poll_cnt + 1;
                if (poll_cnt + 1 >= ack_on_read)
                    avm_readdata <= echo ? {1'b1, 23'd0, last_seq} : ack_value;
                else
                    avm_readdata <= pre_ack_value;
            end else if (avm_address == 2'd2) begin
                rsp_rd_total <= rsp_rd_total + 1;
                avm_readdata <= echo ? {24'hA50000, last_seq} : rsp_value;
            end else begin
                avm_readdata <= 32'hBAD0_0000;
            end
        end
    end

    // Drives one command and completes the response handshake (no checking here).
    task automatic run_txn(input logic [15:0] cmd, output int lat, output logic [31:0] rdata,
                           output logic rto, output logic ok);
        int n;
        ok = 1'b0; lat = 0; rdata = 32'd0; rto = 1'b0;
        cmd_data = cmd;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) return;
        lat = n;
        rdata = rsp_data;
        rto = rsp_timeout;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_ready, busy, rsp_valid, rsp_timeout, avm_chipselect, avm_write, avm_read}
            !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 1000000", {cmd_ready, busy, rsp_valid,
                     rsp_timeout, avm_chipselect, avm_write, avm_read});
        end
        total++;
        if (rsp_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_rsp_data: got %h want 0", rsp_data);
        end
        total++;
        if ({avm_address, avm_writedata, avm_byteenable} !== {2'd0, 32'd0, 4'hF}) begin
            bad++;
            $display("FAIL reset_avm: got addr=%0d wd=%h be=%h want 0 0 f",
                     avm_address, avm_writedata, avm_byteenable);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd; logic to; logic ok; int w0;
        echo = 1'b0; ack_on_read = 1; ack_value = 32'h8000_0001;
        pre_ack_value = 32'd0; rsp_value = 32'hDEAD_BEEF;
        w0 = wr_cnt;
        run_txn(16'h0C1C, lat, rd, to, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", ok); end
        total++;
        if (wr_cnt - w0 != 3) begin
            bad++; $display("FAIL basic_wr_count: got %0d want 3", wr_cnt - w0);
        end
        total++;
        if ({wr_addr_log[w0], wr_data_log[w0]} !== {2'd0, 32'h0000_0C1C}) begin
            bad++; $display("FAIL basic_word0: got a=%0d d=%h want a=0 d=00000c1c",
                            wr_addr_log[w0], wr_data_log[w0]);
        end
        total++;
        if ({wr_addr_log[w0+1], wr_data_log[w0+1]} !== {2'd1, 32'h0000_0001}) begin
            bad++; $display("FAIL basic_word1: got a=%0d d=%h want a=1 d=00000001",
                            wr_addr_log[w0+1], wr_data_log[w0+1]);
        end
        total++;
        if ({wr_addr_log[w0+2], wr_data_log[w0+2]} !== {2'd3, 32'h0}) begin
            bad++; $display("FAIL basic_clr_ack: got a=%0d d=%h want a=3 d=0",
                            wr_addr_log[w0+2], wr_data_log[w0+2]);
        end
        total++;
        if ({rd, to} !== {32'hDEAD_BEEF, 1'b0}) begin
            bad++; $display("FAIL basic_rsp: got %h/%b want deadbeef/0", rd, to);
        end
        total++;
        if (lat != 16) begin bad++; $display("FAIL basic_latency: got %0d want 16", lat); end
        total++;
        if ({cmd_ready, busy, rsp_valid, rsp_data} !== {3'b100, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL basic_after: got rdy=%b busy=%b v=%b d=%h want 1 0 0 deadbeef",
                            cmd_ready, busy, rsp_valid, rsp_data);
        end
    endtask

    task automatic test_poll_gap();
        int lat; logic [31:0] rd; logic to; logic ok; int p0; int r0;
        echo = 1'b0; ack_on_read = 3; ack_value = 32'h8000_0002;
        pre_ack_value = 32'd0; rsp_value = 32'h1234_5678;
        p0 = poll_total; r0 = rsp_rd_total;
        run_txn(16'h0ABC, lat, rd, to, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL gap_done: got %b want 1", ok); end
        total++;
        if (poll_total - p0 != 3) begin
            bad++; $display("FAIL gap_polls: got %0d want 3", poll_total - p0);
        end
        total++;
        if (poll_cyc_log[p0+1] - poll_cyc_log[p0] != 10) begin
            bad++; $display("FAIL gap_space1: got %0d want 10", poll_cyc_log[p0+1] - poll_cyc_log[p0]);
        end
        total++;
        if (poll_cyc_log[p0+2] - poll_cyc_log[p0+1] != 10) begin
            bad++; $display("FAIL gap_space2: got %0d want 10",
                            poll_cyc_log[p0+2] - poll_cyc_log[p0+1]);
        end
        total++;
        if (rsp_rd_total - r0 != 1) begin
            bad++; $display("FAIL gap_rsp_reads: got %0d want 1", rsp_rd_total - r0);
        end
        total++;
        if (rd !== 32'h1234_5678) begin bad++; $display("FAIL gap_rsp: got %h want 12345678", rd); end
        total++;
        if (lat != 36) begin bad++; $display("FAIL gap_latency: got %0d want 36", lat); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic to; logic ok; int w0; int n; logic found;
        echo = 1'b0; ack_on_read = 1000000; pre_ack_value = 32'd0;
        cmd_data = 16'h0041;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            if (avm_chipselect && avm_read && avm_address == 2'd3) found = 1'b1;
        end
        total++;
        if (found !== 1'b1) begin bad++; $display("FAIL rstmid_poll_seen: got %b want 1", found); end
        @(negedge clk);
        reset = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        total++;
        if ({avm_chipselect, avm_write, avm_read, cmd_ready, busy} !== 5'b00010) begin
            bad++; $display("FAIL rstmid_idle: got %b want 00010",
                            {avm_chipselect, avm_write, avm_read, cmd_ready, busy});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (wr_cnt != w0) begin bad++; $display("FAIL rstmid_no_clear: got %0d want %0d", wr_cnt, w0); end
        echo = 1'b1; ack_on_read = 1;
        run_txn(16'h0042, lat, rd, to, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_next_done: got %b want 1", ok); end
        total++;
        if ({wr_addr_log[w0+1], wr_data_log[w0+1]} !== {2'd1, 32'd1}) begin
            bad++; $display("FAIL rstmid_seq: got a=%0d d=%h want a=1 d=1",
                            wr_addr_log[w0+1], wr_data_log[w0+1]);
        end
        total++;
        if (rd !== 32'hA500_0001) begin bad++; $display("FAIL rstmid_rsp: got %h want a5000001", rd); end
    endtask

    task automatic test_stale_ack();
        int lat; logic [31:0] rd; logic to; logic ok; int w0; int p0;
        echo = 1'b1; ack_on_read = 1;
        for (int s = 2; s <= 5; s++) begin
            run_txn(16'(s), lat, rd, to, ok);
            total++;
            if (ok !== 1'b1) begin bad++; $display("FAIL stale_filler%0d: got %b want 1", s, ok); end
        end
        echo = 1'b0; pre_ack_value = 32'h8000_0005; ack_on_read = 4;
        ack_value = 32'h8000_0006; rsp_value = 32'hCAFE_F00D;
        w0 = wr_cnt; p0 = poll_total;
        run_txn(16'h0FFF, lat, rd, to, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL stale_done: got %b want 1", ok); end
        total++;
        if (wr_data_log[w0+1] !== 32'd6) begin
            bad++; $display("FAIL stale_seq: got %h want 6", wr_data_log[w0+1]);
        end
        total++;
        if (poll_total - p0 != 4) begin
            bad++; $display("FAIL stale_polls: got %0d want 4", poll_total - p0);
        end
        total++;
        if (lat != 46) begin bad++; $display("FAIL stale_latency: got %0d want 46", lat); end
        total++;
        if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL stale_rsp: got %h want cafef00d", rd); end
    endtask

`ifdef MAILBOX_TIMEOUT_EN
    task automatic test_timeout();
        int lat; logic [31:0] rd; logic to; logic ok;
        echo = 1'b0; ack_on_read = 1000000; pre_ack_value = 32'd0; rsp_value = 32'h5555_5555;
        run_txn(16'h0123, lat, rd, to, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL timeout_done: got %b want 1", ok); end
        total++;
        if ({to, rd} !== {1'b1, 32'd0}) begin
            bad++; $display("FAIL timeout_rsp: got to=%b d=%h want 1 0", to, rd);
        end
        total++;
        if ({wr_addr_log[wr_cnt-1], wr_data_log[wr_cnt-1]} !== {2'd3, 32'd0}) begin
            bad++; $display("FAIL timeout_clr: got a=%0d d=%h want a=3 d=0",
                            wr_addr_log[wr_cnt-1], wr_data_log[wr_cnt-1]);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int w0; int n; logic held; logic [7:0] exp_seq;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        echo = 1'b1; ack_on_read = 1; pre_ack_value = 32'd0;
        w0 = wr_cnt;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_seq = 8'(i + 1);
            cmd_data = 16'(i);
            total++;
            if (cmd_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_idle%0d: got %b want 1", i, cmd_ready);
                break;
            end
            @(negedge clk);
            n = 1;
            while (!rsp_valid && n < 3000) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (n != 16) begin bad++; $display("FAIL b2b_latency%0d: got %0d want 16", i, n); end
            if (!rsp_valid) break;
            held = 1'b1;
            repeat (3) begin
                @(negedge clk);
                held &= rsp_valid;
            end
            total++;
            if (held !== 1'b1) begin bad++; $display("FAIL b2b_hold%0d: got %b want 1", i, held); end
            total++;
            if (rsp_data !== {24'hA50000, exp_seq}) begin
                bad++; $display("FAIL b2b_rsp%0d: got %h want %h", i, rsp_data, {24'hA50000, exp_seq});
            end
            total++;
            if (wr_data_log[w0 + 3*i + 1] !== {24'd0, exp_seq}) begin
                bad++; $display("FAIL b2b_seq%0d: got %h want %h", i, wr_data_log[w0 + 3*i + 1],
                                {24'd0, exp_seq});
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = 16'd0;
        rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_poll_gap();
        test_reset_mid();
        test_stale_ack();
`ifdef MAILBOX_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
